// File: rtl/sl_pkg.sv
// Shared definitions for the serial-line (SL) transmitter and receiver:
// FSM states, {sl1,sl0} symbol encodings and the odd-parity helper.
package sl_pkg;

    typedef enum logic [2:0] {
        SL_IDLE,
        SL_PULSE,
        SL_GAP,
        SL_STOP,
        SL_STOP_GAP
    } sl_tx_state_t;

    localparam logic [1:0] SL_SYM_IDLE = 2'b11;
    localparam logic [1:0] SL_SYM_ZERO = 2'b10;
    localparam logic [1:0] SL_SYM_ONE  = 2'b01;
    localparam logic [1:0] SL_SYM_STOP = 2'b00;

    // Callers zero-extend narrower words; the extra zeros do not change parity.
    localparam int SL_PARITY_MAX_W = 64;

    function automatic logic sl_odd_parity(input logic [SL_PARITY_MAX_W-1:0] data);
        return ~^data;
    endfunction

    function automatic logic [1:0] sl_bit_symbol(input logic b);
        return b ? SL_SYM_ONE : SL_SYM_ZERO;
    endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// Loadable down-counter that times pulse and gap phases; done is high
// while the count sits at zero.
module sl_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/sl_transmitter.sv
// SL transmitter: pops words from a FWFT FIFO and sends them LSB first as
// low pulses on sl0/sl1, followed by an odd-parity bit and a stop symbol.
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int DATA_SIZE = 8,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] fifo_data,
    input  logic                 fifo_empty,
    output logic                 fifo_inc,
    output logic                 sl0,
    output logic                 sl1,
    output logic                 busy
);

    localparam int PH_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BC_W   = $clog2(DATA_SIZE + 1);

    localparam logic [PH_W-1:0] PULSE_RELOAD = PH_W'(PULSE_LEN - 1);
    localparam logic [PH_W-1:0] GAP_RELOAD   = PH_W'(GAP_LEN - 1);

    sl_tx_state_t           r_state;
    logic [DATA_SIZE-1:0]   r_pend;
    logic                   r_parity;
    logic [BC_W-1:0]        r_bitcnt;
    logic [1:0]             r_lines;
    logic                   r_busy;

    logic                   w_start;
    logic                   w_load;
    logic [PH_W-1:0]        w_load_val;
    logic                   w_done;
    logic                   w_next_bit;

    // r_pend holds only the bits not yet put on the line, so bit 0 is always
    // the next data bit; the first bit goes straight from fifo_data[0].
    always_comb begin
        w_start    = (r_state == SL_IDLE) && enable && !fifo_empty;
        w_load     = (r_state == SL_IDLE) || w_done;
        w_next_bit = (r_bitcnt == BC_W'(DATA_SIZE - 1)) ? r_parity : r_pend[0];
        case (r_state)
            SL_PULSE, SL_STOP: w_load_val = GAP_RELOAD;
            default:           w_load_val = PULSE_RELOAD;
        endcase
    end

    sl_phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= SL_IDLE;
            r_pend   <= '0;
            r_parity <= 1'b0;
            r_bitcnt <= '0;
            r_lines  <= SL_SYM_IDLE;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                SL_IDLE: begin
                    r_lines <= SL_SYM_IDLE;
                    r_busy  <= 1'b0;
                    if (w_start) begin
                        r_state  <= SL_PULSE;
                        r_pend   <= fifo_data >> 1;
                        r_parity <= sl_odd_parity(SL_PARITY_MAX_W'(fifo_data));
                        r_bitcnt <= '0;
                        r_lines  <= sl_bit_symbol(fifo_data[0]);
                        r_busy   <= 1'b1;
                    end
                end
                SL_PULSE: begin
                    if (w_done) begin
                        r_state <= SL_GAP;
                        r_lines <= SL_SYM_IDLE;
                    end
                end
                SL_GAP: begin
                    if (w_done) begin
                        if (r_bitcnt < BC_W'(DATA_SIZE)) begin
                            r_state  <= SL_PULSE;
                            r_pend   <= r_pend >> 1;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            r_lines  <= sl_bit_symbol(w_next_bit);
                        end else begin
                            r_state <= SL_STOP;
                            r_lines <= SL_SYM_STOP;
                        end
                    end
                end
                SL_STOP: begin
                    if (w_done) begin
                        r_state <= SL_STOP_GAP;
                        r_lines <= SL_SYM_IDLE;
                    end
                end
                SL_STOP_GAP: begin
                    if (w_done) begin
                        r_state <= SL_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= SL_IDLE;
                    r_lines <= SL_SYM_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst_n so no word is popped while the FSM is held in reset.
    assign fifo_inc = w_start && rst_n;
    assign sl0      = r_lines[0];
    assign sl1      = r_lines[1];
    assign busy     = r_busy;

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench for sl_transmitter: each popped word queues its expected
// cycle-by-cycle line/busy waveform, which is consumed as the DUT runs.
module tb_sl_transmitter;

    localparam int DW = 8;
    localparam int PL = 4;
    localparam int GL = 4;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_inc;
    logic          sl0;
    logic          sl1;
    logic          busy;

    typedef struct packed {
        logic [1:0] lines;
        logic       busy;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fq[$];
    int            pop_cyc[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pops     = 0;
    int busy_cnt = 0;

    sl_transmitter #(
        .DATA_SIZE (DW),
        .PULSE_LEN (PL),
        .GAP_LEN   (GL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_inc   (fifo_inc),
        .sl0        (sl0),
        .sl1        (sl1),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    // Expected {sl1,sl0} per cycle: data LSB first, odd parity, then stop.
    task automatic push_frame(input logic [DW-1:0] w);
        logic [1:0] sym;
        exp_t       e;
        for (int s = 0; s < DW + 2; s++) begin
            if (s < DW)       sym = w[s] ? 2'b01 : 2'b10;
            else if (s == DW) sym = (~^w) ? 2'b01 : 2'b10;
            else              sym = 2'b00;
            e.busy = 1'b1;
            e.lines = sym;
            for (int k = 0; k < PL; k++) sb.push_back(e);
            e.lines = 2'b11;
            for (int k = 0; k < GL; k++) sb.push_back(e);
        end
    endtask

    task automatic step();
        logic exp_inc;
        exp_t e;
        @(negedge clk);
        cyc++;
        exp_inc = rst_n && (sb.size() == 0) && enable && (fq.size() != 0);
        chk("fifo_inc", fifo_inc, exp_inc);
        if (sb.size() != 0) begin
            e = sb.pop_front();
        end else begin
            e.lines = 2'b11;
            e.busy  = 1'b0;
        end
        chk("lines", {sl1, sl0}, e.lines);
        chk("busy", busy, e.busy);
        if (busy) busy_cnt++;
        if (fifo_inc && fq.size() != 0) begin
            push_frame(fq.pop_front());
            pops++;
            pop_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        drive_fifo();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        int idx;
        rst_n  = 1'b0;
        enable = 1'b0;
        drive_fifo();
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single word 0xA5
        busy_cnt = 0;
        p0 = pops;
        fq.push_back(8'hA5);
        drive_fifo();
        enable = 1'b1;
        repeat (90) step();
        chk("a5_pops", pops - p0, 1);
        chk("a5_busy_len", busy_cnt, 80);

        // Back-to-back parity corner words
        p0  = pops;
        idx = pop_cyc.size();
        fq.push_back(8'h00);
        fq.push_back(8'hFF);
        fq.push_back(8'h01);
        drive_fifo();
        repeat (260) step();
        chk("b2b_pops", pops - p0, 3);
        if (pop_cyc.size() >= idx + 3) begin
            chk("b2b_gap1", pop_cyc[idx+1] - pop_cyc[idx], 81);
            chk("b2b_gap2", pop_cyc[idx+2] - pop_cyc[idx+1], 81);
        end

        // Empty FIFO with enable high
        p0 = pops;
        repeat (200) step();
        chk("empty_pops", pops - p0, 0);

        // enable low blocks start; dropping it mid-frame does not abort
        p0 = pops;
        enable = 1'b0;
        fq.push_back(8'h5A);
        fq.push_back(8'hC3);
        drive_fifo();
        repeat (20) step();
        chk("en0_pops", pops - p0, 0);
        enable = 1'b1;
        repeat (20) step();
        enable = 1'b0;
        repeat (100) step();
        chk("endrop_pops", pops - p0, 1);
        chk("endrop_fifo_left", fq.size(), 1);

        // Reset mid-frame
        p0 = pops;
        enable = 1'b1;
        repeat (31) step();
        fq.push_back(8'h3C);
        rst_n = 1'b0;
        #1;
        chk("rst_lines", {sl1, sl0}, 2'b11);
        chk("rst_busy", busy, 1'b0);
        chk("rst_inc", fifo_inc, 1'b0);
        sb.delete();
        drive_fifo();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (90) step();
        chk("rst_pops", pops - p0, 2);
        chk("rst_fifo_left", fq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sl_transmitter.md
# sl_transmitter

Single-clock serial-line (SL) transmitter that drains words from the read side of the transceiver's asynchronous FIFO and serialises each one onto the two-wire SL line pair. It sits directly downstream of the FIFO in the transmit clock domain. It consumes the FIFO's first-word-fall-through read data and empty flag, and returns a one-cycle pop strobe. Each word is sent LSB first, followed by an odd-parity bit and a stop symbol.

## Interface
Parameters:
- DATA_SIZE, 8, word width; must match the FIFO data width.
- PULSE_LEN, 4, clocks per active (low) pulse; must be ≥1.
- GAP_LEN, 4, clocks per idle (both-high) gap after each pulse; must be ≥1.

Ports:
- clk  input  1  transmit clock; the FIFO read clock.
- rst_n  input  1  reset; asynchronous, active-low.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_data  input  DATA_SIZE  FIFO read data; valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO read-side empty flag.
- fifo_inc  output  1  pop strobe; one cycle per word, combinational from state and inputs.
- sl0  output  1  line 0; low pulse encodes bit 0; registered.
- sl1  output  1  line 1; low pulse encodes bit 1; registered.
- busy  output  1  high while a frame is in progress; registered.

## Operation
- Line encoding:
  - Idle: sl0=sl1=1.
  - Bit 0: sl0 low for PULSE_LEN, then both lines high for GAP_LEN.
  - Bit 1: sl1 low for PULSE_LEN, then both lines high for GAP_LEN.
  - Stop: sl0 and sl1 both low for PULSE_LEN, then both high for GAP_LEN.
- Frame order: data bits LSB first, then the parity bit, then stop.
- Parity rule: the parity bit makes the total count of ones (data plus parity) odd, i.e. parity = ~^data.
- FSM states: IDLE, PULSE, GAP, STOP, STOP_GAP.
  - IDLE → PULSE when enable && !fifo_empty.
    - In that same cycle: fifo_inc=1, fifo_data is latched into the shift register, parity is computed and stored, and the bit counter is cleared.
  - PULSE → GAP after PULSE_LEN cycles.
  - GAP → PULSE after GAP_LEN cycles if bit counter < DATA_SIZE. The shift register is shifted right and the bit counter is incremented on this transition.
  - GAP → STOP after GAP_LEN cycles once bit counter = DATA_SIZE, meaning the parity bit has just been sent.
  - STOP → STOP_GAP after PULSE_LEN cycles.
  - STOP_GAP → IDLE after GAP_LEN cycles.
- Bit counter: $clog2(DATA_SIZE+1) bits, running 0..DATA_SIZE. Index DATA_SIZE selects the parity bit.
- Phase counter: $clog2(max(PULSE_LEN,GAP_LEN)) bits (minimum 1). Reloaded on every state change; counts down to 0.
- enable is sampled only in IDLE. Deasserting it mid-frame does not abort the frame.
- fifo_inc is never asserted outside IDLE, and never while fifo_empty=1.

## Timing
- Reset values: sl0=1, sl1=1, busy=0, fifo_inc=0, state IDLE, all counters 0.
- Let T be the cycle in which fifo_inc=1.
  - The first pulse is visible on sl0/sl1 from T+1.
  - busy goes high at T+1.
- Frame length: (DATA_SIZE+2)·(PULSE_LEN+GAP_LEN) cycles, from T+1 to the last STOP_GAP cycle inclusive. With default parameters this is 80 cycles.
- The earliest next fifo_inc is in the cycle after the last STOP_GAP cycle, i.e. T+81 with defaults.
  - busy is 0 in that cycle and returns to 1 on the following cycle.
- The FIFO's registered empty flag updates within the frame, so there is no pop hazard.
- Reset mid-frame: lines return high and busy goes low asynchronously. The word already popped is discarded and is not re-popped.

## Structure
- Shared package sl_pkg holds:
  - the state enum sl_tx_state_t;
  - localparams for the line symbol encodings (IDLE=2'b11, ZERO=2'b10, ONE=2'b01, STOP=2'b00 on {sl1,sl0});
  - a parity helper function, reused by the future sl_receiver.
- Sub-module sl_phase_timer: loadable down-counter with a done flag, parameterised width. Instantiated once.

## Test plan
- Word 0xA5, default parameters:
  - Required bit sequence 1,0,1,0,0,1,0,1, then parity 1, then stop.
  - Each pulse lasts 4 cycles, followed by a 4-cycle gap.
  - fifo_inc is high exactly once; busy is high for 80 cycles.
- Words 0x00 and 0xFF: parity bit is 1 for both. Word 0x01: parity bit is 0.
- Two words queued back-to-back: second fifo_inc arrives exactly 81 cycles after the first; no extra pops.
- fifo_empty=1 with enable=1 for 200 cycles: lines stay high, fifo_inc stays 0.
- enable=0 with a word available: no pop. enable dropped at cycle 20 of a frame: the frame completes and no new frame starts.
- rst_n asserted at cycle 30 of a frame: sl0=sl1=1 and busy=0 immediately. After release with the FIFO non-empty, the next word starts cleanly from bit 0.
